// File: rtl/toggle_cover_detect.sv
// Toggle coverage detector: per-bit rise/fall report pulses plus a sticky covered mask and hit counter.
// Latency: a toggle sampled at edge t is reported on valid_o and counted from t until edge t+1 (one cycle).
// Backpressure: none; the downstream reporter must accept one report word per cycle. en_i low suspends sampling.
//
// Build option: define TOGGLE_COVER_ONCE_EN so that each cover point reports only once per reset/clear epoch.
// Without it, every detected toggle pulses its valid bit. The mask, hit count and all-covered flag behave the
// same way in both builds.

module toggle_cover_detect #(
  parameter  int WIDTH  = 8,
  localparam int POINTS = 2 * WIDTH,
  localparam int CW     = $clog2(POINTS + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [WIDTH-1:0]  sig_i,
  input  logic              clear_i,
  output logic [POINTS-1:0] valid_o,
  output logic [CW-1:0]     hit_count_o,
  output logic              all_covered_o
);

  // INIT: no previous sample held yet, so no toggle can be judged.
  // RUN:  prev_q holds the last enabled sample.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [POINTS-1:0]   mask_q, mask_d;
  logic [POINTS-1:0]   valid_q, valid_d;
  logic [CW-1:0]       hit_q, hit_d;
  logic                all_q, all_d;

  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic                sample_run;
  logic [POINTS-1:0]   det;
  logic [POINTS-1:0]   new_bits;
  logic [CW-1:0]       new_cnt;
  logic [CW-1:0]       hit_sum;

  // Edge detection against the held sample; only meaningful when running and enabled.
  always_comb begin
    rise       = ~prev_q & sig_i;
    fall       = prev_q & ~sig_i;
    sample_run = (state_q == ST_RUN) && en_i;
    det        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      det[2*i]   = sample_run & rise[i];
      det[2*i+1] = sample_run & fall[i];
    end
  end

  // Points hit for the first time this epoch, and how many of them there are.
  always_comb begin
    new_bits = det & ~mask_q;
    new_cnt  = '0;
    for (int k = 0; k < POINTS; k++) begin
      new_cnt = new_cnt + CW'(new_bits[k]);
    end
    // Mask bits are only ever newly set once, so the sum is bounded by POINTS.
    hit_sum = hit_q + new_cnt;
  end

  // Next state and next datapath values; clear wins over any detection at the same edge.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    mask_d  = mask_q;
    valid_d = '0;
    hit_d   = hit_q;
    all_d   = all_q;

    // prev tracks every enabled sample, including the capturing edge in INIT and edges with clear.
    if (en_i) begin
      prev_d = sig_i;
    end

    unique case (state_q)
      ST_INIT: begin
        // First enabled edge only captures; nothing to compare against yet.
        if (en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mask_d = mask_q | det;
        hit_d  = hit_sum;
        all_d  = (hit_sum == CW'(POINTS));
`ifdef TOGGLE_COVER_ONCE_EN
        valid_d = new_bits;
`else
        valid_d = det;
`endif
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (clear_i) begin
      mask_d  = '0;
      valid_d = '0;
      hit_d   = '0;
      all_d   = 1'b0;
    end
  end

  // State register; reset dominates clear and enable and drops any pending detection.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
      prev_q  <= '0;
      mask_q  <= '0;
      valid_q <= '0;
      hit_q   <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      all_q   <= all_d;
    end
  end

  assign valid_o       = valid_q;
  assign hit_count_o   = hit_q;
  assign all_covered_o = all_q;

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Bench for toggle_cover_detect at WIDTH=4: directed steps push hand-computed expectations,
// a monitor pops one entry per clock and compares valid, hit count and all-covered.
// Works in both builds; the repeated-rise expectation follows TOGGLE_COVER_ONCE_EN.

module tb_toggle_cover_detect;

  localparam int WIDTH  = 4;
  localparam int POINTS = 2 * WIDTH;
  localparam int CW     = $clog2(POINTS + 1);

  logic              clk;
  logic              reset;
  logic              en;
  logic [WIDTH-1:0]  sig;
  logic              clear;
  logic [POINTS-1:0] valid;
  logic [CW-1:0]     hit_count;
  logic              all_covered;

  typedef struct {
    logic [POINTS-1:0] v;
    logic [CW-1:0]     h;
    logic              a;
    string             name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef TOGGLE_COVER_ONCE_EN
  localparam logic [7:0] REPEAT_RISE_V = 8'h00;
  localparam logic [7:0] MIXED_FULL_V  = 8'h54;
`else
  localparam logic [7:0] REPEAT_RISE_V = 8'h01;
  localparam logic [7:0] MIXED_FULL_V  = 8'h56;
`endif

  toggle_cover_detect #(.WIDTH(WIDTH)) dut (
    .clock_i       (clk),
    .reset_i       (reset),
    .en_i          (en),
    .sig_i         (sig),
    .clear_i       (clear),
    .valid_o       (valid),
    .hit_count_o   (hit_count),
    .all_covered_o (all_covered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after every rising edge, compare the outputs against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.v) begin
          errors++;
          $display("FAIL %s valid: got %h expected %h", e.name, valid, e.v);
        end
        checks++;
        if (hit_count !== e.h) begin
          errors++;
          $display("FAIL %s hit_count: got %0d expected %0d", e.name, hit_count, e.h);
        end
        checks++;
        if (all_covered !== e.a) begin
          errors++;
          $display("FAIL %s all_covered: got %b expected %b", e.name, all_covered, e.a);
        end
      end
    end
  end

  // Drive one edge worth of inputs and queue what the outputs must show after that edge.
  task automatic step(input logic r, input logic e_in, input logic c, input logic [WIDTH-1:0] s,
                      input logic [POINTS-1:0] ev, input logic [CW-1:0] eh, input logic ea,
                      input string name);
    exp_t x;
    @(negedge clk);
    reset = r;
    en    = e_in;
    clear = c;
    sig   = s;
    x.v = ev;
    x.h = eh;
    x.a = ea;
    x.name = name;
    exp_q.push_back(x);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    clear = 1'b0;
    sig   = '0;

    // Reset state, and reset dominating clear/en.
    step(1, 0, 0, 4'b0000, 8'h00, 0, 0, "reset");
    step(1, 1, 1, 4'b1111, 8'h00, 0, 0, "reset_prio");

    // Capture edge then a single rise on bit 0.
    step(0, 1, 0, 4'b0000, 8'h00, 0, 0, "init_capture");
    step(0, 1, 0, 4'b0001, 8'h01, 1, 0, "rise0");
    // Fall on bit 0, then a repeated rise.
    step(0, 1, 0, 4'b0000, 8'h02, 2, 0, "fall0");
    step(0, 1, 0, 4'b0001, REPEAT_RISE_V, 2, 0, "repeat_rise0");

    // Full coverage from all-rise then all-fall.
    step(1, 0, 0, 4'b0000, 8'h00, 0, 0, "reset2");
    step(0, 1, 0, 4'b0000, 8'h00, 0, 0, "init_capture2");
    step(0, 1, 0, 4'b1111, 8'h55, 4, 0, "all_rise");
    step(0, 1, 0, 4'b0000, 8'hAA, 8, 1, "all_fall");
    step(0, 0, 0, 4'b1111, 8'h00, 8, 1, "hold_disabled_full");

    // Clear beats a simultaneous toggle; the next toggle counts afresh.
    step(0, 1, 1, 4'b0010, 8'h00, 0, 0, "clear_with_toggle");
    step(0, 1, 0, 4'b0000, 8'h08, 1, 0, "fall1_after_clear");

    // Toggles while disabled are invisible; re-enable compares to held prev.
    step(0, 0, 0, 4'b0000, 8'h00, 1, 0, "dis_a");
    step(0, 0, 0, 4'b1111, 8'h00, 1, 0, "dis_b");
    step(0, 0, 0, 4'b0000, 8'h00, 1, 0, "dis_c");
    step(0, 1, 0, 4'b0011, 8'h05, 3, 0, "reenable");
    step(0, 1, 0, 4'b0011, 8'h00, 3, 0, "steady");

    // Clear in INIT stays in INIT; the next enabled edge is still a capture.
    step(1, 0, 0, 4'b0000, 8'h00, 0, 0, "reset3");
    step(0, 0, 1, 4'b0000, 8'h00, 0, 0, "clear_in_init");
    step(0, 1, 0, 4'b0101, 8'h00, 0, 0, "capture_after_clear");
    step(0, 1, 0, 4'b0100, 8'h02, 1, 0, "fall0_b");

    // Reset coinciding with a toggle discards it; first edge after reset only captures.
    step(1, 1, 0, 4'b0000, 8'h00, 0, 0, "reset_with_toggle");
    step(0, 1, 0, 4'b1111, 8'h00, 0, 0, "capture_after_reset");
    step(0, 1, 0, 4'b1110, 8'h02, 1, 0, "fall0_c");
    // Rises and falls on different bits in the same cycle.
    step(0, 1, 0, 4'b0001, 8'hA9, 5, 0, "mixed_rise_fall");
    step(0, 1, 0, 4'b1110, MIXED_FULL_V, 8, 1, "mixed_to_full");
    // Clear alone, while disabled.
    step(0, 0, 1, 4'b1110, 8'h00, 0, 0, "clear_disabled");

    // Let the monitor drain, within a bounded number of cycles.
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
